// File: rtl/rx_cam_seq.sv
// Camera power/reset sequencer and RX capture-enable controller (AXI4-Lite clock domain).
// Optional frame watchdog in SYNC/RUN is built when RX_CAM_SEQ_WDOG_EN is defined.
module rx_cam_seq #(
  parameter int CNT_W       = 24,
  parameter int PWR_CYC     = 100000,
  parameter int RST_CYC     = 200000,
  parameter int SKIP_FRAMES = 2,
  parameter int WDOG_CYC    = 4000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       frame_done_i,
  input  logic       size_err_i,
  output logic       cam_pwdn_o,
  output logic       cam_rstn_o,
  output logic       rx_enable_o,
  output logic       rst_size_err_o,
  output logic       ready_o,
  output logic [2:0] state_o,
  output logic [7:0] retry_cnt_o,
  output logic       wdog_trip_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PWR_WAIT = 3'd1,
    RST_WAIT = 3'd2,
    SYNC     = 3'd3,
    RUN      = 3'd4,
    RECOVER  = 3'd5
  } state_t;

  function automatic int max1(input int n);
    return (n > 1) ? n : 1;
  endfunction

  localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(max1(PWR_CYC) - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(max1(RST_CYC) - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      frm_q, frm_d;
  logic [1:0]       guard_q, guard_d;
  logic [7:0]       retry_q, retry_d;
  logic             clr_d;
  logic             trip_d;
  logic             wdog_exp;

`ifdef RX_CAM_SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LD = CNT_W'(max1(WDOG_CYC) - 1);

  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             wdog_load;

  // Reload on entering SYNC/RUN and on every frame while staying there.
  always_comb begin
    wdog_load = (state_d == SYNC || state_d == RUN) &&
                (state_d != state_q || frame_done_i);
    if (wdog_load)
      wdog_d = WDOG_LD;
    else if (wdog_q != '0)
      wdog_d = wdog_q - CNT_W'(1);
    else
      wdog_d = '0;
  end

  assign wdog_exp = (wdog_q == '0) && !frame_done_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign wdog_exp = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    frm_d   = frm_q;
    guard_d = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    retry_d = retry_q;
    clr_d   = 1'b0;
    trip_d  = 1'b0;

    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = PWR_WAIT;
          cnt_d   = PWR_LD;
          retry_d = '0;
        end
        PWR_WAIT: if (cnt_q == '0) begin
          state_d = RST_WAIT;
          cnt_d   = RST_LD;
        end
        RST_WAIT: if (cnt_q == '0) begin
          state_d = SYNC;
          clr_d   = 1'b1;
          frm_d   = '0;
          guard_d = 2'd2;  // mask size_err_i while the clear pulse takes effect
        end
        SYNC, RUN: begin
          trip_d = wdog_exp;
          if ((size_err_i && guard_q == 2'd0) || wdog_exp) begin
            state_d = RECOVER;
            cnt_d   = RST_LD;
            if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
          end else if (state_q == SYNC) begin
            if (SKIP_FRAMES == 0) begin
              state_d = RUN;
            end else if (frame_done_i) begin
              if (int'(frm_q) + 1 >= SKIP_FRAMES) state_d = RUN;
              else                                frm_d   = frm_q + 16'd1;
            end
          end
        end
        RECOVER: if (cnt_q == '0) begin
          state_d = RST_WAIT;
          cnt_d   = RST_LD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      frm_q          <= '0;
      guard_q        <= 2'd0;
      retry_q        <= '0;
      cam_pwdn_o     <= 1'b1;
      cam_rstn_o     <= 1'b0;
      rx_enable_o    <= 1'b0;
      rst_size_err_o <= 1'b0;
      ready_o        <= 1'b0;
      wdog_trip_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frm_q          <= frm_d;
      guard_q        <= guard_d;
      retry_q        <= retry_d;
      cam_pwdn_o     <= (state_d == IDLE);
      cam_rstn_o     <= (state_d inside {RST_WAIT, SYNC, RUN});
      rx_enable_o    <= (state_d inside {SYNC, RUN});
      rst_size_err_o <= clr_d;
      ready_o        <= (state_d == RUN);
      wdog_trip_o    <= trip_d;
    end
  end

  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_rx_cam_seq.sv
// Scoreboard bench for rx_cam_seq: a behavioural model queues the expected outputs per
// applied cycle and a monitor compares them against the DUT half a cycle later.
module tb_rx_cam_seq;

  localparam int PWR  = 4;
  localparam int RST  = 6;
  localparam int SKIP = 2;
  localparam int WDOG = 20;
`ifdef RX_CAM_SEQ_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  typedef struct packed {
    logic       pwdn;
    logic       rstn;
    logic       rx_en;
    logic       clr;
    logic       ready;
    logic [2:0] st;
    logic [7:0] retry;
    logic       trip;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_i, enable_i, frame_done_i, size_err_i;
  logic       cam_pwdn_o, cam_rstn_o, rx_enable_o, rst_size_err_o, ready_o, wdog_trip_o;
  logic [2:0] state_o;
  logic [7:0] retry_cnt_o;

  rx_cam_seq #(
    .CNT_W(24), .PWR_CYC(PWR), .RST_CYC(RST), .SKIP_FRAMES(SKIP), .WDOG_CYC(WDOG)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .frame_done_i(frame_done_i),
    .size_err_i(size_err_i), .cam_pwdn_o(cam_pwdn_o), .cam_rstn_o(cam_rstn_o),
    .rx_enable_o(rx_enable_o), .rst_size_err_o(rst_size_err_o), .ready_o(ready_o),
    .state_o(state_o), .retry_cnt_o(retry_cnt_o), .wdog_trip_o(wdog_trip_o)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model: phase number, cycles spent in it, frames seen, cycles since SYNC
  // entry and since the last frame.
  int m_st = 0, m_age = 0, m_frames = 0, m_since_sync = 0, m_since_frame = 0, m_retry = 0;
  bit m_clr = 0, m_trip = 0;

  function automatic int max1(input int n);
    return (n > 1) ? n : 1;
  endfunction

  function void model_advance(input bit r, input bit e, input bit f, input bit s);
    int  nxt;
    bit  err, trip;
    m_clr  = 0;
    m_trip = 0;
    if (r) begin
      m_st = 0; m_age = 0; m_retry = 0;
      return;
    end
    if (!e) begin
      m_st = 0; m_age = 0;
      return;
    end
    nxt = m_st;
    case (m_st)
      0: begin nxt = 1; m_retry = 0; end
      1: if (m_age + 1 >= max1(PWR)) nxt = 2;
      2: if (m_age + 1 >= max1(RST)) begin nxt = 3; m_clr = 1; m_frames = 0; end
      3, 4: begin
        err  = s && (m_since_sync >= 2);
        trip = WDOG_ON && (m_since_frame >= WDOG - 1) && !f;
        m_trip = trip;
        if (err || trip) begin
          nxt = 5;
          if (m_retry < 255) m_retry++;
        end else if (m_st == 3) begin
          if (f) m_frames++;
          if (m_frames >= SKIP) nxt = 4;
        end
      end
      5: if (m_age + 1 >= max1(RST)) nxt = 2;
      default: nxt = 0;
    endcase
    m_since_sync++;
    m_since_frame = f ? 0 : m_since_frame + 1;
    m_age = (nxt != m_st) ? 0 : m_age + 1;
    if (nxt == 3 && m_st != 3) begin m_since_sync = 0; m_since_frame = 0; end
    if (nxt == 4 && m_st != 4) m_since_frame = 0;
    m_st = nxt;
  endfunction

  function obs_t model_obs();
    obs_t o;
    o.pwdn  = (m_st == 0);
    o.rstn  = (m_st == 2 || m_st == 3 || m_st == 4);
    o.rx_en = (m_st == 3 || m_st == 4);
    o.clr   = m_clr;
    o.ready = (m_st == 4);
    o.st    = 3'(m_st);
    o.retry = 8'(m_retry);
    o.trip  = m_trip;
    return o;
  endfunction

  task automatic step(input bit r, input bit e, input bit f, input bit s);
    @(negedge clk);
    rst_i = r; enable_i = e; frame_done_i = f; size_err_i = s;
    model_advance(r, e, f, s);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle_cycles(input int n, input bit e);
    repeat (n) step(1'b0, e, 1'b0, 1'b0);
  endtask

  // Monitor: one expectation per applied cycle, compared just after the edge.
  always @(posedge clk) begin
    obs_t act, exp_o;
    cyc++;
    #1;
    if (exp_q.size() != 0) begin
      exp_o = exp_q.pop_front();
      act   = '{cam_pwdn_o, cam_rstn_o, rx_enable_o, rst_size_err_o, ready_o,
                state_o, retry_cnt_o, wdog_trip_o};
      n_vec++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL outputs cycle %0d: got pwdn/rstn/rxen/clr/rdy=%b%b%b%b%b st=%0d retry=%0d trip=%b, expected %b%b%b%b%b st=%0d retry=%0d trip=%b",
                 cyc, act.pwdn, act.rstn, act.rx_en, act.clr, act.ready, act.st, act.retry, act.trip,
                 exp_o.pwdn, exp_o.rstn, exp_o.rx_en, exp_o.clr, exp_o.ready, exp_o.st, exp_o.retry, exp_o.trip);
      end
    end
  end

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; frame_done_i = 1'b0; size_err_i = 1'b0;

    // Reset with enable already high, then power-up into SYNC.
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(11, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycles(4, 1'b1);

    // Size error in RUN, full recovery and resync.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle_cycles(14, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycles(3, 1'b1);

    // Disable in RUN, re-enable, disable in PWR_WAIT, re-enable to RUN.
    idle_cycles(3, 1'b0);
    idle_cycles(2, 1'b1);
    idle_cycles(2, 1'b0);
    idle_cycles(11, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    // Long frameless stretch in RUN.
    idle_cycles(100, 1'b1);

    // Continuous size error: retry count must saturate at 255.
    repeat (260 * 15 + 20) step(1'b0, 1'b1, 1'b0, 1'b1);
    idle_cycles(20, 1'b1);

    // Randomized traffic with occasional resets and disables.
    for (int blk = 0; blk < 30; blk++) begin
      int fd_rate;
      fd_rate = (blk % 3 == 0) ? 40 : 8;
      repeat (100) step($urandom_range(0, 499) == 0, $urandom_range(0, 149) != 0,
                        $urandom_range(0, fd_rate - 1) == 0, $urandom_range(0, 39) == 0);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_cam_seq.md
Name: rx_cam_seq

Overview:
- Camera power/reset sequencer and capture-enable controller for the video RX path, AXI4-Lite clock domain.
- Drives cam_pwdn, cam_rstn, rx_enable and rst_size_err of the RX config interface from one software enable bit.
- Discards the first frames after reset, then reports ready.
- On frame-size errors (and optionally a frame watchdog), resets and resyncs the camera automatically.

Parameters:
- CNT_W, 24, width of the timing down-counter
- PWR_CYC, 100000, cycles cam_pwdn is low before cam_rstn releases (PWR_WAIT length)
- RST_CYC, 200000, cycles after cam_rstn release before rx_enable; also RECOVER hold length
- SKIP_FRAMES, 2, frame_done pulses discarded in SYNC before RUN (0 = go to RUN on first cycle of SYNC)
- WDOG_CYC, 4000000, max cycles between frame_done pulses in SYNC/RUN (only with the optional feature)

Ports:
- clk_i  in  1  AXI4-Lite clock
- rst_i  in  1  synchronous reset, active-high
- enable_i  in  1  software enable; level
- frame_done_i  in  1  one-cycle pulse per completed frame (already in clk_i domain)
- size_err_i  in  1  level, sticky frame-size error from RX status
- cam_pwdn_o  out  1  camera power-down
- cam_rstn_o  out  1  camera reset, active-low
- rx_enable_o  out  1  RX capture enable
- rst_size_err_o  out  1  one-cycle clear pulse for the sticky size error
- ready_o  out  1  high only in RUN
- state_o  out  3  IDLE=0, PWR_WAIT=1, RST_WAIT=2, SYNC=3, RUN=4, RECOVER=5
- retry_cnt_o  out  8  recoveries since leaving IDLE; saturates at 255
- wdog_trip_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (rst_i=1): state IDLE, cam_pwdn_o=1, cam_rstn_o=0, rx_enable_o=0, rst_size_err_o=0, ready_o=0, retry_cnt_o=0, wdog_trip_o=0, counter=0.
- All outputs are registered.
- Output levels per state (pwdn/rstn/rx_en):
  - IDLE: 1/0/0
  - PWR_WAIT: 0/0/0
  - RST_WAIT: 0/1/0
  - SYNC: 0/1/1
  - RUN: 0/1/1
  - RECOVER: 0/0/0
- Timed states: on entry the counter loads max(N,1)-1, where N is the state's cycle count. The counter decrements each cycle. The state exits on the cycle after the counter reads 0, so the state lasts exactly max(N,1) cycles.
- Transitions:
  - IDLE -> PWR_WAIT when enable_i=1. retry_cnt cleared on this transition.
  - PWR_WAIT -> RST_WAIT after PWR_CYC cycles.
  - RST_WAIT -> SYNC after RST_CYC cycles. rst_size_err_o pulses for exactly one cycle on the first SYNC cycle. Frame counter cleared.
  - SYNC -> RUN when frame_done_i has been seen SKIP_FRAMES times. A pulse coinciding with the SYNC entry cycle is counted.
  - SYNC or RUN -> RECOVER when size_err_i=1. size_err_i is ignored on the first SYNC cycle and the following cycle, while the clear pulse propagates.
  - RECOVER -> RST_WAIT after RST_CYC cycles. retry_cnt +1 (saturating) on entry to RECOVER.
- Priority: enable_i=0 overrides everything; any state -> IDLE on the next cycle. Next is size_err_i, then frame_done_i. A size error and a frame_done in the same SYNC cycle go to RECOVER; the frame is not counted.
- enable_i held high in IDLE with rst_i: reset wins. Leaves IDLE on the first cycle after rst_i drops.
- Reset mid-sequence returns to IDLE outputs on the next edge; no partial-sequence state is retained.

Optional Feature:
- Macro: RX_CAM_SEQ_WDOG_EN.
- Defined: a watchdog counter runs in SYNC and RUN.
  - Reloaded to WDOG_CYC-1 on state entry and on every frame_done_i.
  - On reaching 0 with no pulse: wdog_trip_o pulses one cycle, state -> RECOVER (retry_cnt increments).
  - A size error in the same cycle takes the RECOVER path with one retry increment only, and wdog_trip_o still pulses.
- Not defined: no watchdog logic; wdog_trip_o tied to 0. The SYNC/RUN state persists indefinitely without frames.

Test Plan:
- Test parameters: PWR_CYC=4, RST_CYC=6, SKIP_FRAMES=2, WDOG_CYC=20.
- Power-up: rst_i high 3 cycles, then enable_i=1 at cycle T -> cam_pwdn_o falls at T+1, cam_rstn_o rises at T+5, rx_enable_o rises and rst_size_err_o pulses at T+11; ready_o stays 0.
- Frame skip: two frame_done_i pulses in SYNC -> ready_o=1 and state_o=4 one cycle after the second pulse; a single pulse leaves state_o=3.
- Size-error recovery: size_err_i=1 in RUN -> next cycle state_o=5, cam_rstn_o=0, rx_enable_o=0, retry_cnt_o=1; 6 cycles later RST_WAIT, 6 more cycles then SYNC with a fresh rst_size_err_o pulse.
- Disable mid-sequence: enable_i=0 during PWR_WAIT, and separately in RUN -> next cycle all outputs at IDLE values; re-enable restarts the full timing and clears retry_cnt_o.
- Saturation: force 260 recoveries -> retry_cnt_o holds 255.
- With RX_CAM_SEQ_WDOG_EN: no frame_done_i for 20 cycles in RUN -> wdog_trip_o one pulse, state_o=5; without the macro, 100 idle cycles in RUN -> state_o stays 4, wdog_trip_o=0.
